regfile_dump_ctrl: RTL and testbench
====================================

# regfile_dump_ctrl

Hardware debug reader for the processor register bank: on a start request it freezes the core, walks R0..R(NREGS-1) through a dedicated register-file read port, and streams each value out over a valid/ready handshake. It sits beside the datapath register file, which is the writer, and is the synthesizable counterpart of the simulation-only register dump. R15 is never read; it is the PC and is not stored in the bank.

## Interface
- NREGS, 15: number of registers dumped, starting at R0. Legal range 1..15; elaboration fails outside this range.
- clk  in  1  rising-edge clock, shared with the datapath
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request to begin a dump; ignored unless in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last beat is accepted
- hold  out  1  stall request to the core; high from SYNC through SEND of the last register
- ra  out  4  register-file read address, driven with the current index
- rd  in  32  register-file read data, combinational from ra
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts the beat when out_valid and out_ready are both high
- out_idx  out  4  register number of the current beat
- out_data  out  32  registered value of R[out_idx]
- out_last  out  1  high with out_valid on the beat for R(NREGS-1)

## Operation
- States: IDLE, SYNC, READ, SEND, DONE.
- IDLE:
  - start=1: idx<=0, go to SYNC.
  - Otherwise stay in IDLE.
- SYNC:
  - Lasts exactly 1 cycle with hold=1, so a regfile write issued in the start cycle lands before any read.
  - Go to READ.
- READ:
  - ra=idx.
  - At the clock edge: out_data<=rd, out_idx<=idx. Go to SEND.
- SEND:
  - out_valid=1. out_data and out_idx stay stable until accepted.
  - out_ready=0: stay in SEND.
  - out_ready=1 and idx==NREGS-1: go to DONE.
  - out_ready=1 otherwise: idx<=idx+1, go to READ.
- DONE:
  - done=1 for exactly 1 cycle; hold=0. Go to IDLE.
- ra drives idx in every state; it is meaningful only in READ.
- idx is 4 bits and never exceeds NREGS-1, so no wrap-around occurs. It never addresses 4'hF.
- start arriving while busy has no effect and is not queued.
- Reset mid-dump: all outputs drop asynchronously and the FSM returns to IDLE. No done pulse is produced and the partial stream is abandoned.
- Reset values: busy=0, done=0, hold=0, ra=0, out_valid=0, out_idx=0, out_data=0, out_last=0, state=IDLE.

## Timing
- start sampled high at edge E0. SYNC runs E0..E1, READ runs E1..E2, so the first out_valid is high after E2.
- With out_ready tied high, each register costs 2 cycles (READ + SEND).
- Last beat accepted at edge E(2·NREGS+1); done is high in the following cycle.
- With NREGS=15: done is high in the cycle after E31, busy falls after E32.
- A back-pressure stall in SEND adds 1 cycle per cycle of out_ready=0. Data and index stay unchanged during the stall.
- hold is registered (decoded from state) and glitch-free. It drops in the same cycle done rises.
- A new start is accepted in the first IDLE cycle after DONE.

## Structure
- Shared package arm_dbg_pkg holds:
  - dump_state_t enum (IDLE, SYNC, READ, SEND, DONE).
  - REG_PC = 4'd15.
  - DUMP_MAX_REGS = 15.
- Single module, no sub-modules: the FSM, index counter and output register are small enough to keep together.
- Top-level wiring:
  - Connect ra/rd to a third read port of the register file.
  - OR hold into the core's stall enable.

## Test plan
- Preload R0..R14 = 0x1000_0000+i; pulse start with out_ready=1 -> 15 beats with out_idx 0..14 and matching data, out_last only on idx 14, done 1 cycle after edge E31.
- Same preload, out_ready toggling 1,0,0,1... -> beats, order and values unchanged; out_data/out_idx stable while stalled; total duration increases by exactly the number of stall cycles.
- Write R0=0xDEAD_BEEF in the same cycle as start -> first beat carries 0xDEAD_BEEF; no write is observed while hold=1.
- start pulsed again mid-dump (at beat 5) -> ignored; exactly 15 beats and one done pulse.
- Assert reset during SEND of R7 -> all outputs 0 asynchronously, no done pulse; a later start yields a full clean dump from R0.
- NREGS=1 -> a single beat with out_idx 0 and out_last=1; done follows in the next cycle; ra never equals 4'hF in any test.

Source files
------------

// File: rtl/arm_dbg_pkg.sv
// Shared debug-path types and constants for the processor register-bank dump logic.
package arm_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        READ = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } dump_state_t;

    // R15 is the PC and lives outside the bank, so a dump can never address it.
    localparam logic [3:0] REG_PC        = 4'd15;
    localparam int         DUMP_MAX_REGS = 15;

    function automatic logic is_hold_state(input dump_state_t s);
        return (s == SYNC) || (s == READ) || (s == SEND);
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Beat stream carrying one register value per handshake from the dump controller to its consumer.
interface regfile_dump_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Debug reader that stalls the core and streams R0..R(NREGS-1) out through a dedicated
// register-file read port, one register per handshake beat.
module regfile_dump_ctrl
    import arm_dbg_pkg::*;
#(
    parameter int NREGS  = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              hold,
    output logic [3:0]        ra,
    input  logic [DATA_W-1:0] rd,
    regfile_dump_ctrl_if.master dump
);

    if (NREGS < 1 || NREGS > DUMP_MAX_REGS || (NREGS - 1) >= int'(REG_PC)) begin : g_bad_nregs
        $error("regfile_dump_ctrl: NREGS must be in 1..15");
    end

    localparam logic [3:0] LAST_IDX = 4'(NREGS - 1);

    dump_state_t       state, state_n;
    logic [3:0]        idx, idx_n;
    logic              busy_n, done_n, hold_n, valid_n, last_n, capture;
    logic [DATA_W-1:0] data_p1;
    logic [3:0]        idx_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SYNC;
                    idx_n   = '0;
                end
            end
            SYNC: state_n = READ;
            READ: state_n = SEND;
            SEND: begin
                if (dump.out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        state_n = READ;
                        idx_n   = idx + 4'd1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        busy_n  = (state_n != IDLE);
        hold_n  = is_hold_state(state_n);
        done_n  = (state_n == DONE);
        valid_n = (state_n == SEND);
        last_n  = (state_n == SEND) && (idx_n == LAST_IDX);
        capture = (state == READ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            hold      <= 1'b0;
            dump.out_valid <= 1'b0;
            dump.out_last  <= 1'b0;
        end else begin
            busy      <= busy_n;
            done      <= done_n;
            hold      <= hold_n;
            dump.out_valid <= valid_n;
            dump.out_last  <= last_n;
        end
    end

    // ---- READ -> SEND boundary: capture read data, held until the beat is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_p1 <= '0;
            idx_p1  <= '0;
        end else if (capture) begin
            data_p1 <= rd;
            idx_p1  <= idx;
        end
    end

    assign dump.out_data = data_p1;
    assign dump.out_idx  = idx_p1;
    assign ra            = idx;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: a behavioural register bank feeds two instances (15 and 1 registers).
module tb_regfile_dump_ctrl;
    import arm_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    int          sel = 0;
    int          edges = 0;
    int          total = 0;
    int          passed = 0;
    logic [31:0] rf [16];

    logic        start0, start1, busy0, busy1, done0, done1, hold0, hold1;
    logic [3:0]  ra0, ra1;
    logic [31:0] rd0, rd1;

    regfile_dump_ctrl_if #(.DATA_W(32)) bus0 ();
    regfile_dump_ctrl_if #(.DATA_W(32)) bus1 ();

    regfile_dump_ctrl #(.NREGS(15), .DATA_W(32)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .hold(hold0), .ra(ra0), .rd(rd0), .dump(bus0.master)
    );

    regfile_dump_ctrl #(.NREGS(1), .DATA_W(32)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .hold(hold1), .ra(ra1), .rd(rd1), .dump(bus1.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    assign rd0 = rf[ra0];
    assign rd1 = rf[ra1];
    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign bus0.out_ready = ready;
    assign bus1.out_ready = ready;

    logic        s_valid, s_last, s_busy, s_done, s_hold;
    logic [3:0]  s_idx, s_ra;
    logic [31:0] s_data;
    assign s_valid = (sel == 1) ? bus1.out_valid : bus0.out_valid;
    assign s_last  = (sel == 1) ? bus1.out_last  : bus0.out_last;
    assign s_idx   = (sel == 1) ? bus1.out_idx   : bus0.out_idx;
    assign s_data  = (sel == 1) ? bus1.out_data  : bus0.out_data;
    assign s_busy  = (sel == 1) ? busy1 : busy0;
    assign s_done  = (sel == 1) ? done1 : done0;
    assign s_hold  = (sel == 1) ? hold1 : hold0;
    assign s_ra    = (sel == 1) ? ra1   : ra0;

    task automatic preload(input bit rnd);
        for (int i = 0; i < 15; i++) rf[i] = rnd ? $urandom : (32'h1000_0000 + 32'(i));
        rf[15] = 32'hFFFF_FFFF;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0 per valid cycle, 2: random ready.
    task automatic run_dump(input int n, input int mode, input bit wr_first, input int restart_beat);
        logic [31:0] exp_data [$];
        int e0, beats, stalls, busy_cnt, hold_cnt, done_cnt, done_edge, vcyc, tail;
        bit prev_stall, ra_bad, hold_bad, finished, rd_ok;
        logic [3:0]  p_idx;
        logic [31:0] p_data;
        beats = 0; stalls = 0; busy_cnt = 0; hold_cnt = 0; done_cnt = 0; done_edge = -1;
        vcyc = 0; tail = 0; prev_stall = 0; ra_bad = 0; hold_bad = 0; finished = 0;
        p_idx = '0; p_data = '0;
        for (int i = 0; i < n; i++) exp_data.push_back(rf[i]);
        if (wr_first) exp_data[0] = 32'hDEAD_BEEF;

        @(negedge clk);
        ready = 1'b1;
        start = 1'b1;
        e0 = edges + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (wr_first) rf[0] = 32'hDEAD_BEEF;

        for (int cyc = 0; cyc < 800 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (s_ra == REG_PC) ra_bad = 1;
            if (s_busy) busy_cnt++;
            if (s_hold) hold_cnt++;
            if (s_hold !== (s_busy && !s_done)) hold_bad = 1;
            if (s_done) begin
                done_cnt++;
                done_edge = edges;
            end
            if (s_valid) begin
                if (prev_stall) begin
                    total++;
                    if (s_idx !== p_idx || s_data !== p_data)
                        $display("FAIL stall_stable: idx %0d data %h, held %0d %h", s_idx, s_data, p_idx, p_data);
                    else passed++;
                end
                case (mode)
                    0: ready = 1'b1;
                    1: ready = (vcyc % 3 == 0);
                    default: ready = 1'($urandom_range(0, 1));
                endcase
                vcyc++;
                if (ready) begin
                    rd_ok = (beats < n);
                    total++;
                    if (!rd_ok || s_idx !== 4'(beats) || s_data !== exp_data[beats] || s_last !== (beats == n - 1))
                        $display("FAIL beat%0d: idx %0d data %h last %b, want idx %0d data %h last %b",
                                 beats, s_idx, s_data, s_last, beats, rd_ok ? exp_data[beats] : 32'h0,
                                 (beats == n - 1));
                    else passed++;
                    if (beats == restart_beat) start = 1'b1;
                    beats++;
                    prev_stall = 0;
                end else begin
                    stalls++;
                    prev_stall = 1;
                    p_idx = s_idx;
                    p_data = s_data;
                end
            end else begin
                ready = 1'b1;
            end
            if (done_cnt > 0 && !s_busy) begin
                tail++;
                if (tail == 3) finished = 1;
            end
        end
        start = 1'b0;
        ready = 1'b1;

        total++;
        if (!finished) $display("FAIL timeout: dump did not finish, beats %0d of %0d", beats, n);
        else passed++;
        total++;
        if (beats !== n) $display("FAIL beat_count: got %0d, want %0d", beats, n);
        else passed++;
        total++;
        if (done_cnt !== 1) $display("FAIL done_pulses: got %0d, want 1", done_cnt);
        else passed++;
        total++;
        if (done_edge !== e0 + 2 * n + 1 + stalls)
            $display("FAIL done_edge: got %0d, want %0d", done_edge - e0, 2 * n + 1 + stalls);
        else passed++;
        total++;
        if (busy_cnt !== 2 * n + 2 + stalls) $display("FAIL busy_cycles: got %0d, want %0d", busy_cnt, 2 * n + 2 + stalls);
        else passed++;
        total++;
        if (hold_cnt !== 2 * n + 1 + stalls || hold_bad)
            $display("FAIL hold_window: got %0d cycles (shape_err %b), want %0d", hold_cnt, hold_bad, 2 * n + 1 + stalls);
        else passed++;
        total++;
        if (ra_bad) $display("FAIL ra_pc: got 15 on ra, want never 15");
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy0, done0, hold0, ra0, bus0.out_valid, bus0.out_last, bus0.out_idx, bus0.out_data} !== '0)
            $display("FAIL reset_dut0: busy %b done %b hold %b ra %0d valid %b idx %0d data %h, want all 0",
                     busy0, done0, hold0, ra0, bus0.out_valid, bus0.out_idx, bus0.out_data);
        else passed++;
        total++;
        if ({busy1, done1, hold1, ra1, bus1.out_valid, bus1.out_last, bus1.out_idx, bus1.out_data} !== '0)
            $display("FAIL reset_dut1: busy %b done %b hold %b valid %b, want all 0", busy1, done1, hold1, bus1.out_valid);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit hit;
        int extra_done;
        hit = 0;
        extra_done = 0;
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (bus0.out_valid && bus0.out_idx == 4'd7) hit = 1;
            else @(negedge clk);
        end
        total++;
        if (!hit) $display("FAIL reach_r7: got no SEND of R7, want one");
        else passed++;
        ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy0, done0, hold0, ra0, bus0.out_valid, bus0.out_last, bus0.out_idx, bus0.out_data} !== '0)
            $display("FAIL async_reset: busy %b done %b hold %b valid %b idx %0d data %h, want all 0",
                     busy0, done0, hold0, bus0.out_valid, bus0.out_idx, bus0.out_data);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done0 || busy0) extra_done++;
        end
        total++;
        if (extra_done !== 0) $display("FAIL after_reset_quiet: got %0d busy/done cycles, want 0", extra_done);
        else passed++;
        run_dump(15, 0, 1'b0, -1);
    endtask

    task automatic test_basic();      sel = 0; preload(1'b0); run_dump(15, 0, 1'b0, -1); endtask
    task automatic test_backpressure(); sel = 0; preload(1'b0); run_dump(15, 1, 1'b0, -1); endtask
    task automatic test_write_in_start(); sel = 0; preload(1'b0); run_dump(15, 0, 1'b1, -1); endtask
    task automatic test_restart_ignored(); sel = 0; preload(1'b0); run_dump(15, 0, 1'b0, 5); endtask
    task automatic test_random();
        sel = 0;
        for (int k = 0; k < 3; k++) begin
            preload(1'b1);
            run_dump(15, 2, 1'b0, -1);
        end
    endtask
    task automatic test_single();
        sel = 1;
        preload(1'b1);
        run_dump(1, 0, 1'b0, -1);
        run_dump(1, 2, 1'b0, -1);
        sel = 0;
    endtask

    initial begin
        preload(1'b0);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_write_in_start();
        test_restart_ignored();
        test_mid_reset();
        test_random();
        test_single();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
